// File: rtl/seq_alu_if.sv
// Request/result bundle between a requester (master) and seq_alu (slave).
interface seq_alu_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] res_val;
  logic [15:0] reg_val;
  logic [15:0] write_data;
  logic        res_we;
  logic        busy;
  logic        done;
  logic        zero;
  logic        carry;

  modport master (
    output start, op, res_val, reg_val,
    input  write_data, res_we, busy, done, zero, carry
  );

  modport slave (
    input  start, op, res_val, reg_val,
    output write_data, res_we, busy, done, zero, carry
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 16-bit ALU (IDLE -> EXEC -> DONE) producing one registered result per request.
// Define SEQ_ALU_MUL_EN to build the 16-cycle shift-add multiplier for op 7.
module seq_alu (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d, reqOp;
  logic [15:0] opA_q, opA_d, opB_q, opB_d;
  logic [15:0] work_q, work_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] writeData_q, writeData_d;
  logic        zero_q, zero_d, carry_q, carry_d;

  logic [15:0] stepResult, execWork;
  logic        stepCarry, lastStep, writeEnable;
  logic [4:0]  execCount;
  logic [16:0] wideSum;
`ifdef SEQ_ALU_MUL_EN
  logic [15:0] prodHi_q, prodHi_d, execProdHi;
`endif

  assign reqOp = op_t'(bus.op);

  // One EXEC step: full result for single-cycle ops, one bit of progress for shifts and MUL.
  always_comb begin
    stepResult = '0;
    stepCarry  = 1'b0;
    lastStep   = 1'b1;
    wideSum    = '0;
    execWork   = work_q;
    execCount  = count_q;
`ifdef SEQ_ALU_MUL_EN
    execProdHi = prodHi_q;
`endif
    unique case (op_q)
      OP_ADD: begin
        wideSum    = {1'b0, opA_q} + {1'b0, opB_q};
        stepResult = wideSum[15:0];
        stepCarry  = wideSum[16];
      end
      OP_SUB: begin
        wideSum    = {1'b0, opA_q} - {1'b0, opB_q};
        stepResult = wideSum[15:0];
        stepCarry  = wideSum[16];
      end
      OP_AND: stepResult = opA_q & opB_q;
      OP_OR:  stepResult = opA_q | opB_q;
      OP_XOR: stepResult = opA_q ^ opB_q;
      OP_SHL: begin
        if (count_q == 5'd0) begin
          stepResult = work_q;
        end else begin
          execWork   = {work_q[14:0], 1'b0};
          execCount  = count_q - 5'd1;
          stepResult = execWork;
          stepCarry  = work_q[15];
          lastStep   = (count_q == 5'd1);
        end
      end
      OP_SHR: begin
        if (count_q == 5'd0) begin
          stepResult = work_q;
        end else begin
          execWork   = {1'b0, work_q[15:1]};
          execCount  = count_q - 5'd1;
          stepResult = execWork;
          stepCarry  = work_q[0];
          lastStep   = (count_q == 5'd1);
        end
      end
`ifdef SEQ_ALU_MUL_EN
      // Product lives in {prodHi_q, work_q}; multiplier bits leave work_q from the bottom.
      OP_MUL: begin
        wideSum    = {1'b0, prodHi_q} + (work_q[0] ? {1'b0, opA_q} : 17'd0);
        execProdHi = wideSum[16:1];
        execWork   = {wideSum[0], work_q[15:1]};
        execCount  = count_q - 5'd1;
        stepResult = execWork;
        stepCarry  = |execProdHi;
        lastStep   = (count_q == 5'd1);
      end
`else
      OP_MUL: stepResult = '0;
`endif
      default: stepResult = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    work_d      = work_q;
    count_d     = count_q;
    writeData_d = writeData_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
`ifdef SEQ_ALU_MUL_EN
    prodHi_d    = prodHi_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EXEC;
          op_d    = reqOp;
          opA_d   = bus.res_val;
          opB_d   = bus.reg_val;
          work_d  = (reqOp == OP_MUL) ? bus.reg_val : bus.res_val;
          count_d = (reqOp == OP_MUL) ? 5'd16 : {1'b0, bus.reg_val[3:0]};
`ifdef SEQ_ALU_MUL_EN
          prodHi_d = '0;
`endif
        end
      end
      EXEC: begin
        work_d  = execWork;
        count_d = execCount;
`ifdef SEQ_ALU_MUL_EN
        prodHi_d = execProdHi;
`endif
        if (lastStep) begin
          state_d     = DONE;
          writeData_d = stepResult;
          zero_d      = (stepResult == 16'd0);
          carry_d     = stepCarry;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      opA_q       <= '0;
      opB_q       <= '0;
      work_q      <= '0;
      count_q     <= '0;
      writeData_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prodHi_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      work_q      <= work_d;
      count_q     <= count_d;
      writeData_q <= writeData_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
`ifdef SEQ_ALU_MUL_EN
      prodHi_q    <= prodHi_d;
`endif
    end
  end

  // Without the multiplier, op 7 completes but must never write the register file.
`ifdef SEQ_ALU_MUL_EN
  assign writeEnable = 1'b1;
`else
  assign writeEnable = (op_q != OP_MUL);
`endif

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.res_we     = (state_q == DONE) && writeEnable;
  assign bus.write_data = writeData_q;
  assign bus.zero       = zero_q;
  assign bus.carry      = carry_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-005 SHALL have port res_val  input  16  accumulator operand A, from the register file res output.
REQ-006 SHALL have port reg_val  input  16  selected-register operand B, from the register file.
REQ-007 SHALL have port write_data  output  16  registered result, feeds the register file write_data.
REQ-008 SHALL have port res_we  output  1  one-cycle strobe: write write_data into res; drives the register file mem_write.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port zero  output  1  result == 0, registered with the result.
REQ-012 SHALL have port carry  output  1  carry/borrow/shift-out/overflow, registered with the result.

Function
REQ-013 SHALL implement states IDLE, EXEC, DONE.
REQ-014 IDLE with start=1 SHALL latch op, A=res_val and B=reg_val, then go to EXEC; otherwise SHALL stay in IDLE.
REQ-015 start outside IDLE SHALL be ignored; no queueing; operands SHALL be immune to input changes after latch.
REQ-016 ADD/SUB/AND/OR/XOR SHALL spend exactly 1 cycle in EXEC, so done rises 2 edges after the start edge.
REQ-017 ADD: result=(A+B) mod 2^16, carry = bit 16 of the 17-bit sum.
REQ-018 SUB: result=(A-B) mod 2^16, carry=1 iff A<B unsigned (borrow).
REQ-019 AND/OR/XOR: bitwise; carry=0.
REQ-020 SHL/SHR: shift amount n=B[3:0]; shift 1 bit per EXEC cycle; logical, zero fill; EXEC lasts max(n,1) cycles.
REQ-021 SHL/SHR carry SHALL be the last bit shifted out; n=0 gives result=A, carry=0.
REQ-022 MUL: shift-add, 16 EXEC cycles; result = low 16 bits of A*B; carry=1 iff high 16 bits nonzero.
REQ-023 EXEC end SHALL register write_data/zero/carry and go to DONE.
REQ-024 DONE SHALL last exactly 1 cycle with done=1 and res_we=1, then go to IDLE.
REQ-025 done and res_we SHALL be 0 in every state other than DONE.
REQ-026 write_data, zero and carry SHALL hold their values until the next DONE.
REQ-027 start asserted in the DONE cycle SHALL be ignored; back-to-back issue SHALL be accepted the following cycle, when state is IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, write_data=0, zero=0, carry=0, busy=0, done=0, res_we=0, independent of clk.
REQ-029 Reset mid-EXEC SHALL abort the operation with no res_we pulse; the partial result SHALL be discarded.
REQ-030 The first start after rst_n rises SHALL be accepted on the first rising edge where rst_n=1.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN SHALL compile in the MUL datapath; when defined, op 7 behaves per REQ-022.
REQ-032 Without SEQ_ALU_MUL_EN, op 7 SHALL take 1 EXEC cycle, give write_data=0, zero=1, carry=0, and pulse done with res_we held 0.

Verification
REQ-033 Reset then ADD with A=0xFFFF, B=0x0001 -> done 2 edges after start, write_data=0x0000, zero=1, carry=1, one res_we pulse.
REQ-034 SUB with A=0x0003, B=0x0005 -> write_data=0xFFFE, carry=1, zero=0; busy high exactly 2 cycles.
REQ-035 SHL with A=0x8001, B=0x0004 -> 4 EXEC cycles, write_data=0x0010, carry=0; SHR with A=0x0001, B=0x0000 -> write_data=0x0001, EXEC 1 cycle.
REQ-036 MUL with A=0x0100, B=0x0101 (SEQ_ALU_MUL_EN defined) -> 16 EXEC cycles, write_data=0x0100, carry=1; undefined -> write_data=0, no res_we.
REQ-037 Start MUL, toggle start and operands at EXEC cycle 5, pull rst_n low at EXEC cycle 8 -> no res_we; all outputs 0 immediately; next ADD 2+3 -> 0x0005.
